// File: rtl/spi_eep_responder.sv
// spi_eep_responder
// ------------------
// SPI slave that models the calibration EEPROM on the DSO's SPI bus. It
// decodes 16-bit command frames ([15:14] opcode, [13:8] address,
// [7:0] data). Reads are two-frame: the read command loads rd_buf, and the
// next frame shifts {8'h00, rd_buf} out on MISO, MSB first.
//
// Ports
//   clk        system clock (the SPI master runs SCLK at clk/16)
//   rst        synchronous active-high reset
//   SS_n       active-low slave select (asynchronous to clk)
//   SCLK       SPI clock, idle high (asynchronous to clk)
//   MOSI       master-to-slave data, MSB first (asynchronous to clk)
//   MISO       slave-to-master data, MSB first, 0 while SS_n is high
//   frame_done one-cycle pulse for a valid decoded 16-bit frame
//   frame_err  one-cycle pulse for a malformed frame or an invalid opcode
//   last_cmd   last fully received frame, valid or not
module spi_eep_responder #(
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  RESET_DATA = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] last_cmd
);

    localparam int DEPTH = 1 << ADDR_W;

    // Pin bundle: bit 2 = SS_n, bit 1 = SCLK, bit 0 = MOSI.
    // Synchronizers reset to the idle bus levels so that no edge is seen
    // when reset releases on an idle bus.
    localparam logic [2:0] PIN_IDLE = 3'b110;
    localparam int         P_SS     = 2;
    localparam int         P_SCLK   = 1;
    localparam int         P_MOSI   = 0;

    logic [2:0] pin_w;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic [2:0] dly_reg;
    logic [2:0] rise_w;
    logic [2:0] fall_w;

    assign pin_w = {SS_n, SCLK, MOSI};

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= PIN_IDLE;
            sync_reg <= PIN_IDLE;
            dly_reg  <= PIN_IDLE;
        end else begin
            meta_reg <= pin_w;
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_edge
            assign rise_w[gi] = sync_reg[gi] & ~dly_reg[gi];
            assign fall_w[gi] = ~sync_reg[gi] & dly_reg[gi];
        end
    endgenerate

    // Edge strobes and levels are registered once more so that every
    // action (state and outputs alike) lands three clocks after the pin
    // change is first sampled, with all of them aligned to each other.
    logic ss_fall_reg;
    logic ss_rise_reg;
    logic sclk_rise_reg;
    logic sclk_fall_reg;
    logic ss_low_reg;
    logic mosi_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_fall_reg   <= 1'b0;
            ss_rise_reg   <= 1'b0;
            sclk_rise_reg <= 1'b0;
            sclk_fall_reg <= 1'b0;
            ss_low_reg    <= 1'b0;
            mosi_reg      <= 1'b0;
        end else begin
            ss_fall_reg   <= fall_w[P_SS];
            ss_rise_reg   <= rise_w[P_SS];
            sclk_rise_reg <= rise_w[P_SCLK];
            sclk_fall_reg <= fall_w[P_SCLK];
            ss_low_reg    <= ~sync_reg[P_SS];
            mosi_reg      <= sync_reg[P_MOSI];
        end
    end

    // Frame state
    logic [4:0]        bit_cnt_reg;
    logic [15:0]       rx_shift_reg;
    logic [15:0]       tx_shift_reg;
    logic [7:0]        rd_buf_reg;
    logic [7:0]        mem_reg [0:DEPTH-1];
    logic              miso_reg;
    logic              frame_done_reg;
    logic              frame_err_reg;
    logic [15:0]       last_cmd_reg;

    logic [1:0]        opcode_w;
    logic [ADDR_W-1:0] addr_w;
    logic [7:0]        data_w;

    // Address bits above ADDR_W are simply not looked at.
    assign opcode_w = rx_shift_reg[15:14];
    assign addr_w   = rx_shift_reg[8 +: ADDR_W];
    assign data_w   = rx_shift_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg    <= 5'd0;
            rx_shift_reg   <= 16'h0000;
            tx_shift_reg   <= 16'h0000;
            rd_buf_reg     <= RESET_DATA;
            miso_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            last_cmd_reg   <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= RESET_DATA;
            end
        end else begin
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            // SS_n edges take priority over any SCLK edge in the same cycle.
            if (ss_fall_reg) begin
                bit_cnt_reg  <= 5'd0;
                tx_shift_reg <= {8'h00, rd_buf_reg};
                // MISO mirrors the new tx_shift[15], which is always 0.
                miso_reg     <= 1'b0;
            end else if (ss_rise_reg) begin
                last_cmd_reg <= rx_shift_reg;
                miso_reg     <= 1'b0;
                if (bit_cnt_reg == 5'd16) begin
                    case (opcode_w)
                        2'b00: begin
                            rd_buf_reg     <= mem_reg[addr_w];
                            frame_done_reg <= 1'b1;
                        end
                        2'b01: begin
                            mem_reg[addr_w] <= data_w;
                            frame_done_reg  <= 1'b1;
                        end
                        default: begin
                            frame_err_reg <= 1'b1;
                        end
                    endcase
                end else begin
                    // Short frame or overrun: discard.
                    frame_err_reg <= 1'b1;
                end
            end else if (ss_low_reg) begin
                if (sclk_rise_reg) begin
                    rx_shift_reg <= {rx_shift_reg[14:0], mosi_reg};
                    if (bit_cnt_reg != 5'd17) begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end else if (sclk_fall_reg && (bit_cnt_reg != 5'd0)) begin
                    // The fall ahead of the first rise must not shift, or
                    // bit 15 would be lost before the master samples it.
                    tx_shift_reg <= {tx_shift_reg[14:0], 1'b0};
                    miso_reg     <= tx_shift_reg[14];
                end
            end
        end
    end

    assign MISO       = miso_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign last_cmd   = last_cmd_reg;

endmodule

// File: tb/tb_spi_eep_responder.sv
// Testbench for spi_eep_responder: drives SPI frames at SCLK = clk/16 and
// checks the returned MISO word, the frame_done/frame_err pulse counts,
// last_cmd and the idle MISO level for each frame.
module tb_spi_eep_responder;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] last_cmd;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    spi_eep_responder #(
        .ADDR_W     (6),
        .RESET_DATA (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .last_cmd   (last_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with each pulse high; a one-cycle pulse adds exactly 1.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One SPI frame: SS_n low, nbits SCLK cycles (fall then rise), SS_n high,
    // then gap clocks of idle. MISO is captured just before each rise.
    task automatic do_frame(input logic [15:0] cmd, input int nbits, input int gap,
                            output logic [15:0] word);
        word = 16'h0000;
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            repeat (8) @(negedge clk);
            word = {word[14:0], MISO};
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] cmd;
        int          nbits;
        logic [15:0] exp_word;
        int          exp_done;
        int          exp_err;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [15:0] word;
        int d0;
        int e0;

        //              cmd       bits word      done err last
        vecs[0]  = '{16'h0305, 16, 16'h0000, 1, 0, 16'h0305}; // read 0x03
        vecs[1]  = '{16'h0000, 16, 16'h0000, 1, 0, 16'h0000}; // dummy
        vecs[2]  = '{16'h41A7, 16, 16'h0000, 1, 0, 16'h41A7}; // write 0x01=A7
        vecs[3]  = '{16'h0100, 16, 16'h0000, 1, 0, 16'h0100}; // read 0x01
        vecs[4]  = '{16'h0000, 16, 16'h00A7, 1, 0, 16'h0000}; // returns A7
        vecs[5]  = '{16'h7F3C, 16, 16'h0000, 1, 0, 16'h7F3C}; // write 0x3F=3C
        vecs[6]  = '{16'h3F00, 16, 16'h0000, 1, 0, 16'h3F00}; // read 0x3F
        vecs[7]  = '{16'h0000, 16, 16'h003C, 1, 0, 16'h0000}; // returns 3C, reads 0x00
        vecs[8]  = '{16'h0000, 16, 16'h0000, 1, 0, 16'h0000}; // addr 0x00 untouched
        vecs[9]  = '{16'h4299, 12, 16'h0000, 0, 1, 16'h0429}; // short write
        vecs[10] = '{16'h4299, 17, 16'h0000, 0, 1, 16'h8532}; // overrun write
        vecs[11] = '{16'h0200, 16, 16'h0000, 1, 0, 16'h0200}; // read 0x02
        vecs[12] = '{16'h0000, 16, 16'h0000, 1, 0, 16'h0000}; // 0x02 still 00
        vecs[13] = '{16'h0100, 16, 16'h0000, 1, 0, 16'h0100}; // rd_buf <= A7
        vecs[14] = '{16'h8255, 16, 16'h00A7, 0, 1, 16'h8255}; // invalid opcode
        vecs[15] = '{16'h0000, 16, 16'h00A7, 1, 0, 16'h0000}; // rd_buf kept A7
        vecs[16] = '{16'h0200, 16, 16'h0000, 1, 0, 16'h0200}; // read 0x02
        vecs[17] = '{16'h0000, 16, 16'h0000, 1, 0, 16'h0000}; // 0x02 not 55

        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_last", {16'd0, last_cmd}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int v = 0; v < 18; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            do_frame(vecs[v].cmd, vecs[v].nbits, 12, word);
            $display("frame %0d cmd=%h bits=%0d miso=%h done=%0d err=%0d last=%h",
                     v, vecs[v].cmd, vecs[v].nbits, word, done_cnt - d0, err_cnt - e0, last_cmd);
            check($sformatf("v%0d_word", v), {16'd0, word}, {16'd0, vecs[v].exp_word});
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_last", v), {16'd0, last_cmd}, {16'd0, vecs[v].exp_last});
            check($sformatf("v%0d_miso_idle", v), {31'd0, MISO}, 32'd0);
        end

        // Full write to 0x04, then a partial write aborted by reset.
        do_frame(16'h44EE, 16, 12, word);
        $display("write 0x04=EE done=%0d", done_cnt);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b0;
            MOSI = (i == 1) || (i == 5);      // upper byte 8'h44
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_last", {16'd0, last_cmd}, 32'd0);
        check("midrst_miso", {31'd0, MISO}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (12) @(negedge clk);
        $display("aborted frame done=%0d err=%0d", done_cnt - d0, err_cnt - e0);
        check("abort_done", done_cnt - d0, 0);
        check("abort_err", err_cnt - e0, 1);

        d0 = done_cnt;
        do_frame(16'h0400, 16, 12, word);
        do_frame(16'h0000, 16, 12, word);
        $display("read 0x04 after reset miso=%h", word);
        check("rst_mem_word", {16'd0, word}, {24'd0, 8'h00});
        check("rst_mem_done", done_cnt - d0, 2);

        // Back-to-back frames with the minimum 4-clk SS_n high gap.
        d0 = done_cnt;
        e0 = err_cnt;
        do_frame(16'h4555, 16, 4, word);
        do_frame(16'h0500, 16, 4, word);
        do_frame(16'h0000, 16, 12, word);
        $display("b2b read 0x05 miso=%h done=%0d err=%0d", word, done_cnt - d0, err_cnt - e0);
        check("b2b_word", {16'd0, word}, 32'h0000_0055);
        check("b2b_done", done_cnt - d0, 3);
        check("b2b_err", err_cnt - e0, 0);

        check("pulse_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
